// File: rtl/seg_scan_if.sv
// Handshake/data bundle between a display producer and seg_scan_ctrl.
interface seg_scan_if #(
  parameter int unsigned DIGITS = 6
);
  logic                  load;
  logic [5*DIGITS-1:0]   dig_code;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic                  lz_en;
  logic [3:0]            bright;
  logic [7:0]            seg_data;
  logic [DIGITS-1:0]     sel;
  logic                  load_ack;
  logic                  frame_start;

  modport master (
    output load, dig_code, dp_mask, blink_mask, lz_en, bright,
    input  seg_data, sel, load_ack, frame_start
  );

  modport slave (
    input  load, dig_code, dp_mask, blink_mask, lz_en, bright,
    output seg_data, sel, load_ack, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: double-buffered frame data, glyph decode,
// leading-zero suppression, blink, dead-time gap and 16-level PWM brightness.
module seg_scan_ctrl #(
  parameter int unsigned DIGITS       = 6,
  parameter int unsigned CNT_SLOT     = 50000,
  parameter int unsigned DEAD         = 500,
  parameter int unsigned BLINK_FRAMES = 250,
  parameter bit          SEL_ACT_HIGH = 1'b1,
  parameter bit          SEG_ACT_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int unsigned SLOT_W = (CNT_SLOT > 1) ? $clog2(CNT_SLOT) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CNT_SLOT - 1);
  localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   = SEL_ACT_HIGH ? '0 : '1;
  localparam logic [7:0]        SEG_OFF   = SEG_ACT_LOW ? 8'hff : 8'h00;

  typedef struct packed {
    logic [5*DIGITS-1:0] code;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blk;
    logic                lz;
  } disp_t;

  localparam disp_t DISP_BLANK = '{code: {DIGITS{5'd31}}, dp: '0, blk: '0, lz: 1'b0};

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic [BLK_W-1:0]  blink_cnt;
  logic              blink_on;
  logic [3:0]        pwm_cnt;
  disp_t             pending, active;
  logic              pend_valid;
  logic [DIGITS-1:0] sel_q;
  logic [7:0]        seg_q;
  logic              ack_q, fs_q;

  logic              slot_wrap, frame_edge;
  logic [4:0]        code_i, cur_code;
  logic              lead, cur_sup, cur_dp, cur_blk;
  logic [7:0]        seg_raw, seg_n;
  logic [DIGITS-1:0] sel_n;

  function automatic logic [7:0] glyph(input logic [4:0] c);
    case (c)
      5'd0:  glyph = 8'hc0;  5'd1:  glyph = 8'hf9;  5'd2:  glyph = 8'ha4;
      5'd3:  glyph = 8'hb0;  5'd4:  glyph = 8'h99;  5'd5:  glyph = 8'h92;
      5'd6:  glyph = 8'h82;  5'd7:  glyph = 8'hf8;  5'd8:  glyph = 8'h80;
      5'd9:  glyph = 8'h90;  5'd10: glyph = 8'h88;  5'd11: glyph = 8'h83;
      5'd12: glyph = 8'hc6;  5'd13: glyph = 8'ha1;  5'd14: glyph = 8'h86;
      5'd15: glyph = 8'h8e;  5'd16: glyph = 8'hbf;  5'd17: glyph = 8'h89;
      5'd18: glyph = 8'hc7;  5'd19: glyph = 8'h8c;
      default: glyph = 8'hff;
    endcase
  endfunction

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_edge = slot_wrap && (dig_idx == IDX_LAST);

  always_comb begin
    lead     = 1'b1;
    code_i   = '0;
    cur_code = 5'd31;
    cur_sup  = 1'b0;
    cur_dp   = 1'b0;
    cur_blk  = 1'b0;
    // Suppression of digit i depends on every digit to its left, so walk them all.
    for (int unsigned i = 0; i < DIGITS; i++) begin
      code_i = active.code[5*i +: 5];
      if (dig_idx == IDX_W'(i)) begin
        cur_code = code_i;
        cur_sup  = active.lz && lead && (code_i == 5'd0) && (i != DIGITS - 1);
        cur_dp   = active.dp[i];
        cur_blk  = active.blk[i];
      end
      lead = lead && ((code_i == 5'd0) || (code_i >= 5'd20));
    end

    seg_raw    = cur_sup ? 8'hff : glyph(cur_code);
    seg_raw[7] = ~cur_dp;

    if (slot_cnt < DEAD_END) begin
      sel_n = '0;
      seg_n = 8'hff;
    end else begin
      sel_n = DIGITS'(1) << dig_idx;
      if ((!blink_on && cur_blk) || !((pwm_cnt < bus.bright) || (bus.bright == 4'hf)))
        seg_n = 8'hff;
      else
        seg_n = seg_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      dig_idx    <= '0;
      pwm_cnt    <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
      active     <= DISP_BLANK;
      pending    <= DISP_BLANK;
      pend_valid <= 1'b0;
      sel_q      <= SEL_OFF;
      seg_q      <= SEG_OFF;
      ack_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_wrap)
        dig_idx <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
      pwm_cnt <= pwm_cnt + 4'd1;
      sel_q   <= SEL_ACT_HIGH ? sel_n : ~sel_n;
      seg_q   <= SEG_ACT_LOW ? seg_n : ~seg_n;
      fs_q    <= frame_edge;
      ack_q   <= frame_edge && pend_valid;

      if (frame_edge) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
        if (pend_valid)
          active <= pending;
      end

      // A load on the frame edge commits the old pending and stays pending itself.
      if (bus.load) begin
        pending    <= '{code: bus.dig_code, dp: bus.dp_mask, blk: bus.blink_mask, lz: bus.lz_en};
        pend_valid <= 1'b1;
      end else if (frame_edge) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign bus.sel         = sel_q;
  assign bus.seg_data    = seg_q;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;
endmodule
